// File: rtl/register_status_file.sv
// Architectural register status file: per-register value plus a busy/tag pair that
// marks registers still waiting on an in-flight ROB entry, with a commit-bus read bypass.
module register_status_file (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rdy,
    input  logic        i_rob_flush,
    input  logic        i_rename_flag,
    input  logic [3:0]  i_rename_tag,
    input  logic [4:0]  i_rename_reg,
    input  logic        i_rename_writes_rd,
    input  logic        i_commit_flag,
    input  logic [3:0]  i_commit_rename,
    input  logic [4:0]  i_commit_dest,
    input  logic [31:0] i_commit_value,
    input  logic        i_commit_is_branch,
    input  logic        i_commit_is_store,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    output logic [31:0] o_rs1_value,
    output logic [31:0] o_rs2_value,
    output logic        o_rs1_busy,
    output logic        o_rs2_busy,
    output logic [3:0]  o_rs1_tag,
    output logic [3:0]  o_rs2_tag,
    output logic [31:0] o_commit_count
);

    logic [31:0] r_value [32];
    logic        r_busy  [32];
    logic [3:0]  r_tag   [32];
    logic [31:0] r_commit_count;

    logic        w_commit_wr;
    logic        w_rename_wr;

    logic [4:0]  w_rd_addr  [2];
    logic [31:0] w_rd_value [2];
    logic        w_rd_busy  [2];
    logic [3:0]  w_rd_tag   [2];

    // Branches, stores and x0 never update the value array; a flush drops the rename.
    assign w_commit_wr = i_commit_flag & ~i_commit_is_branch & ~i_commit_is_store
                       & (i_commit_dest != 5'd0);
    assign w_rename_wr = i_rename_flag & i_rename_writes_rd & (i_rename_reg != 5'd0)
                       & ~i_rob_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_commit_count <= '0;
            for (int i = 0; i < 32; i++) begin
                r_value[i] <= '0;
                r_busy[i]  <= 1'b0;
                r_tag[i]   <= '0;
            end
        end else if (i_rdy) begin
            if (i_commit_flag) begin
                r_commit_count <= r_commit_count + 32'd1;
            end
            if (w_commit_wr) begin
                r_value[i_commit_dest] <= i_commit_value;
            end
            // Entry 0 is never touched so it holds its reset value of all zeros.
            for (int i = 1; i < 32; i++) begin
                if (i_rob_flush) begin
                    r_busy[i] <= 1'b0;
                end else if (w_rename_wr && (i_rename_reg == 5'(i))) begin
                    r_busy[i] <= 1'b1;
                    r_tag[i]  <= i_rename_tag;
                end else if (w_commit_wr && (i_commit_dest == 5'(i)) && r_busy[i]
                             && (r_tag[i] == i_commit_rename)) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    assign w_rd_addr[0] = i_rs1_addr;
    assign w_rd_addr[1] = i_rs2_addr;

    // A matching commit is forwarded only when it will actually land on this edge.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rd_value[p] = '0;
            w_rd_busy[p]  = 1'b0;
            w_rd_tag[p]   = '0;
            if (w_rd_addr[p] != 5'd0) begin
                w_rd_value[p] = r_value[w_rd_addr[p]];
                w_rd_busy[p]  = r_busy[w_rd_addr[p]];
                w_rd_tag[p]   = r_tag[w_rd_addr[p]];
                if (i_rdy && w_commit_wr && (i_commit_dest == w_rd_addr[p])
                    && r_busy[w_rd_addr[p]]
                    && (r_tag[w_rd_addr[p]] == i_commit_rename)) begin
                    w_rd_value[p] = i_commit_value;
                    w_rd_busy[p]  = 1'b0;
                end
            end
        end
    end

    assign o_rs1_value    = w_rd_value[0];
    assign o_rs1_busy     = w_rd_busy[0];
    assign o_rs1_tag      = w_rd_tag[0];
    assign o_rs2_value    = w_rd_value[1];
    assign o_rs2_busy     = w_rd_busy[1];
    assign o_rs2_tag      = w_rd_tag[1];
    assign o_commit_count = r_commit_count;

endmodule

// File: tb/tb_register_status_file.sv
// Table-driven bench for register_status_file: one row per clock cycle, read ports and
// commit count compared mid-cycle, plus hand sequences for asynchronous reset.
module tb_register_status_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        robFlush;
    logic        renameFlag;
    logic [3:0]  renameTag;
    logic [4:0]  renameReg;
    logic        renameWritesRd;
    logic        commitFlag;
    logic [3:0]  commitRename;
    logic [4:0]  commitDest;
    logic [31:0] commitValue;
    logic        commitIsBranch;
    logic        commitIsStore;
    logic [4:0]  rs1Addr;
    logic [4:0]  rs2Addr;
    logic [31:0] rs1Value;
    logic [31:0] rs2Value;
    logic        rs1Busy;
    logic        rs2Busy;
    logic [3:0]  rs1Tag;
    logic [3:0]  rs2Tag;
    logic [31:0] commitCount;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rdy;
        logic        flush;
        logic        renFlag;
        logic        renWr;
        logic [3:0]  renTag;
        logic [4:0]  renReg;
        logic        cmtFlag;
        logic        cmtBr;
        logic        cmtSt;
        logic [3:0]  cmtTag;
        logic [4:0]  cmtDest;
        logic [31:0] cmtVal;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] v1;
        logic [31:0] v2;
        logic        b1;
        logic        b2;
        logic [3:0]  t1;
        logic [3:0]  t2;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];
    vec_t r;

    register_status_file dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_rdy             (rdy),
        .i_rob_flush       (robFlush),
        .i_rename_flag     (renameFlag),
        .i_rename_tag      (renameTag),
        .i_rename_reg      (renameReg),
        .i_rename_writes_rd(renameWritesRd),
        .i_commit_flag     (commitFlag),
        .i_commit_rename   (commitRename),
        .i_commit_dest     (commitDest),
        .i_commit_value    (commitValue),
        .i_commit_is_branch(commitIsBranch),
        .i_commit_is_store (commitIsStore),
        .i_rs1_addr        (rs1Addr),
        .i_rs2_addr        (rs2Addr),
        .o_rs1_value       (rs1Value),
        .o_rs2_value       (rs2Value),
        .o_rs1_busy        (rs1Busy),
        .o_rs2_busy        (rs2Busy),
        .o_rs1_tag         (rs1Tag),
        .o_rs2_tag         (rs2Tag),
        .o_commit_count    (commitCount)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic newRow(input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] cnt);
        r = '{default: '0};
        r.rdy = 1'b1;
        r.a1  = a1;
        r.a2  = a2;
        r.cnt = cnt;
    endtask

    task automatic setRen(input logic [4:0] rg, input logic [3:0] tg);
        r.renFlag = 1'b1;
        r.renWr   = 1'b1;
        r.renReg  = rg;
        r.renTag  = tg;
    endtask

    task automatic setCmt(input logic [3:0] tg, input logic [4:0] dst, input logic [31:0] val);
        r.cmtFlag = 1'b1;
        r.cmtTag  = tg;
        r.cmtDest = dst;
        r.cmtVal  = val;
    endtask

    task automatic exp1(input logic [31:0] v, input logic b, input logic [3:0] t);
        r.v1 = v; r.b1 = b; r.t1 = t;
    endtask

    task automatic exp2(input logic [31:0] v, input logic b, input logic [3:0] t);
        r.v2 = v; r.b2 = b; r.t2 = t;
    endtask

    task automatic pushRow();
        vecs.push_back(r);
    endtask

    task automatic driveIdle();
        rdy = 1'b1; robFlush = 1'b0;
        renameFlag = 1'b0; renameTag = '0; renameReg = '0; renameWritesRd = 1'b0;
        commitFlag = 1'b0; commitRename = '0; commitDest = '0; commitValue = '0;
        commitIsBranch = 1'b0; commitIsStore = 1'b0;
        rs1Addr = '0; rs2Addr = '0;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rdy = v.rdy; robFlush = v.flush;
        renameFlag = v.renFlag; renameWritesRd = v.renWr;
        renameTag = v.renTag; renameReg = v.renReg;
        commitFlag = v.cmtFlag; commitIsBranch = v.cmtBr; commitIsStore = v.cmtSt;
        commitRename = v.cmtTag; commitDest = v.cmtDest; commitValue = v.cmtVal;
        rs1Addr = v.a1; rs2Addr = v.a2;
        #1;
    endtask

    initial begin
        // Row expectations describe the read ports and count during that cycle, before its edge.
        newRow(5, 0, 0); setRen(5, 3); exp1(0, 0, 0); pushRow();
        newRow(5, 0, 0); setCmt(3, 5, 32'hDEADBEEF); exp1(32'hDEADBEEF, 0, 0); pushRow();
        newRow(5, 0, 1); exp1(32'hDEADBEEF, 0, 0); pushRow();
        newRow(7, 5, 1); setRen(7, 2); exp1(0, 0, 0); exp2(32'hDEADBEEF, 0, 0); pushRow();
        newRow(7, 0, 1); setRen(7, 9); exp1(0, 1, 2); pushRow();
        newRow(7, 0, 1); setCmt(2, 7, 32'h11); exp1(0, 1, 9); pushRow();
        newRow(7, 0, 2); exp1(32'h11, 1, 9); pushRow();
        newRow(7, 0, 2); setCmt(9, 7, 32'h22); exp1(32'h22, 0, 0); pushRow();
        newRow(7, 0, 3); exp1(32'h22, 0, 0); pushRow();
        newRow(0, 0, 3); setRen(0, 6); setCmt(6, 0, 32'h55); pushRow();
        newRow(0, 0, 4); pushRow();
        newRow(3, 4, 4); setRen(3, 4); pushRow();
        newRow(3, 4, 4); setRen(4, 5); exp1(0, 1, 4); pushRow();
        newRow(3, 4, 4); r.flush = 1'b1; setRen(9, 2); setCmt(1, 6, 32'h7);
        exp1(0, 1, 4); exp2(0, 1, 5); pushRow();
        newRow(3, 4, 5); pushRow();
        newRow(6, 9, 5); exp1(32'h7, 0, 0); pushRow();
        newRow(10, 0, 5); setRen(10, 7); pushRow();
        newRow(10, 0, 5); setRen(10, 8); setCmt(7, 10, 32'hA5A5); exp1(32'hA5A5, 0, 0); pushRow();
        newRow(10, 0, 6); exp1(32'hA5A5, 1, 8); pushRow();
        newRow(8, 0, 6); r.rdy = 1'b0; setCmt(1, 8, 32'h99); r.cmtBr = 1'b1; pushRow();
        newRow(8, 0, 6); setCmt(1, 8, 32'h99); r.cmtBr = 1'b1; pushRow();
        newRow(8, 0, 7); pushRow();
        newRow(11, 0, 7); setRen(11, 3); pushRow();
        newRow(11, 0, 7); r.rdy = 1'b0; setCmt(3, 11, 32'h1234); exp1(0, 1, 3); pushRow();
        newRow(11, 0, 7); exp1(0, 1, 3); pushRow();
        newRow(11, 0, 7); setCmt(3, 11, 32'h1234); r.cmtSt = 1'b1; exp1(0, 1, 3); pushRow();
        newRow(11, 0, 8); exp1(0, 1, 3); pushRow();

        driveIdle();
        rst_n = 1'b0;
        rs1Addr = 5'd5;
        #2;
        checkOutput("reset rs1_value", rs1Value, 32'h0);
        checkOutput("reset rs1_busy", {31'h0, rs1Busy}, 32'h0);
        checkOutput("reset commit_count", commitCount, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("row%0d rs1_value", i), rs1Value, vecs[i].v1);
            checkOutput($sformatf("row%0d rs1_busy", i), {31'h0, rs1Busy}, {31'h0, vecs[i].b1});
            if (vecs[i].b1 || vecs[i].a1 == 5'd0)
                checkOutput($sformatf("row%0d rs1_tag", i), {28'h0, rs1Tag}, {28'h0, vecs[i].t1});
            checkOutput($sformatf("row%0d rs2_value", i), rs2Value, vecs[i].v2);
            checkOutput($sformatf("row%0d rs2_busy", i), {31'h0, rs2Busy}, {31'h0, vecs[i].b2});
            if (vecs[i].b2 || vecs[i].a2 == 5'd0)
                checkOutput($sformatf("row%0d rs2_tag", i), {28'h0, rs2Tag}, {28'h0, vecs[i].t2});
            checkOutput($sformatf("row%0d commit_count", i), commitCount, vecs[i].cnt);
        end

        // Mid-cycle asynchronous reset while a rename and commit are being presented.
        @(negedge clk);
        driveIdle();
        rs1Addr = 5'd5; rs2Addr = 5'd7;
        renameFlag = 1'b1; renameWritesRd = 1'b1; renameReg = 5'd12; renameTag = 4'd1;
        commitFlag = 1'b1; commitRename = 4'd0; commitDest = 5'd12; commitValue = 32'h77;
        #1;
        checkOutput("prereset rs1_value", rs1Value, 32'hDEADBEEF);
        checkOutput("prereset commit_count", commitCount, 32'd8);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset rs1_value", rs1Value, 32'h0);
        checkOutput("midreset rs2_value", rs2Value, 32'h0);
        checkOutput("midreset commit_count", commitCount, 32'h0);
        @(negedge clk);
        rs1Addr = 5'd12;
        #1;
        checkOutput("heldreset x12 value", rs1Value, 32'h0);
        checkOutput("heldreset x12 busy", {31'h0, rs1Busy}, 32'h0);
        checkOutput("heldreset commit_count", commitCount, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("postreset x12 value", rs1Value, 32'h77);
        checkOutput("postreset x12 busy", {31'h0, rs1Busy}, 32'h1);
        checkOutput("postreset x12 tag", {28'h0, rs1Tag}, 32'h1);
        checkOutput("postreset commit_count", commitCount, 32'd1);
        driveIdle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
